text_overlay_engine: RTL and testbench
======================================

// Module: text_overlay_engine
// PURPOSE
//  Parametrised text sprite renderer for the VGA overlay path. Holds a runtime-writable string of glyph codes,
//  scales each 8x16 alphabet_rom glyph by SCALE and places the string anywhere on screen. Adds typewriter reveal
//  and blink animations timed off frame_start. Output is_text feeds the colour mapper.
// PARAMETERS
//  MAX_CHARS     16  string buffer depth (chars); IDX_W = $clog2(MAX_CHARS)
//  SCALE         7   integer glyph magnification (1..7)
//  GAP           6   blank pixels between character cells (screen px)
//  FRAMES_PER_CH 4   frames between revealed chars (typewriter)
//  BLINK_FRAMES  30  frames per blink half-period
//  BLANK_CODE    0   glyph code written to every buffer slot at reset
// PORTS
//  Clk          in   1          50 MHz system clock
//  Reset        in   1          synchronous, active-high
//  frame_start  in   1          1-cycle pulse at start of each frame
//  DrawX,DrawY  in   10 each    current pixel coordinates
//  wr_en        in   1          write wr_code into buffer[wr_idx]
//  wr_idx       in   IDX_W      buffer slot
//  wr_code      in   6          glyph code (alphabet_rom index)
//  start        in   1          latch config and (re)start animation
//  cfg_len      in   IDX_W+1    string length, sampled on start
//  cfg_x,cfg_y  in   10 each    top-left of string, sampled on start
//  cfg_mode     in   2          text_pkg::mode_t, sampled on start
//  is_text      out  1          pixel is lit glyph pixel (2-cycle latency)
//  busy         out  1          typewriter reveal in progress
//  done         out  1          1-cycle pulse when reveal completes
// BEHAVIOUR
//  Reset: buffer <= BLANK_CODE; len,x,y,mode,reveal_cnt,frame_cnt,blink_cnt,blink_phase <= 0; is_text,busy,done <= 0.
//   Reset mid-animation aborts immediately; nothing drawn until next start (len=0).
//  Config: on start, len <= min(cfg_len, MAX_CHARS); x,y,mode latched; reveal_cnt,frame_cnt,blink_cnt <= 0;
//   blink_phase <= on. Writes affect the display from the next cycle; config ports are ignored except on start.
//  Geometry: PITCH = 8*SCALE+GAP. dx = DrawX-x, dy = DrawY-y (11-bit, negative => outside).
//   In box iff 0<=dx<len*PITCH and 0<=dy<16*SCALE. ci = dx/PITCH, r = dx%PITCH; r>=8*SCALE => gap => off.
//   col = r/SCALE (0=MSB of rom byte), row = dy/SCALE; addr = {buffer[ci],4'b0}+row. Constant divisors only.
//  Pipeline: S1 registers addr, col, vis; S2 registers is_text = vis & rom_data[col]. Latency exactly 2 Clk;
//   no stall. Off-screen parts of the box are simply never addressed.
//  Modes: STATIC(0) vis = inbox. TYPE(1) vis = inbox & ci<reveal_cnt. BLINK(2) vis = inbox & blink_phase.
//   TYPE_BLINK(3) = TYPE rules; blink starts only after reveal completes (phase held on until then).
//  Reveal FSM IDLE->REVEAL->HOLD: start with TYPE/TYPE_BLINK and len>0 -> REVEAL, busy=1.
//   Each frame_start increments frame_cnt; at FRAMES_PER_CH-1 it wraps, reveal_cnt++.
//   When reveal_cnt reaches len -> HOLD, busy=0, done=1 for one cycle. len=0 -> HOLD with done pulse next cycle.
//   STATIC/BLINK start -> HOLD, reveal_cnt=len, no done pulse.
//  Blink: blink_cnt counts frame_start pulses, wraps at BLINK_FRAMES-1 and toggles blink_phase.
//  Simultaneous: start with frame_start -> start wins, frame not counted. start while busy restarts from 0.
//   wr_en to the char currently being drawn: new glyph visible from the next pixel evaluation.
// STRUCTURE
//  text_pkg: mode_t enum {STATIC,TYPE,BLINK,TYPE_BLINK}; CHAR_W=8, CHAR_H=16; glyph code localparams
//   (A=1..Z=26 alphabet_rom order, BLANK).
//  Sub-module text_anim_ctrl: reveal FSM, frame/blink counters, busy/done. Top keeps buffer, geometry, pipeline,
//   alphabet_rom instance.
// TESTING
//  1 Reset, write "WIN" (0x17,0x09,0x0e) at x=460 y=40 SCALE=5 GAP=5 STATIC -> is_text matches W/I/N glyph bitmaps
//    at 2-cycle latency; pixel (460+40..+44, any row) in gap is 0.
//  2 TYPE, len=3, FRAMES_PER_CH=4 -> ch0 visible after 4 frame_starts, all after 12; busy falls and done pulses once
//    on frame 12.
//  3 BLINK, BLINK_FRAMES=30 -> text on frames 0-29, off 30-59, on 60+; TYPE_BLINK: no blinking before done.
//  4 cfg_len=20 with MAX_CHARS=16 -> len clamps to 16; dx beyond 16*PITCH gives 0; cfg_x=600 clips at screen edge.
//  5 start coincident with frame_start mid-reveal -> reveal_cnt=0, frame not counted; Reset mid-reveal -> busy=0,
//    is_text=0 within 2 cycles.
//  6 wr_en to slot 1 while displaying -> new glyph visible next pixel; len=0 start -> done pulse, nothing drawn.

Source files
------------

// File: rtl/text_pkg.sv
// Shared types and constants for the text overlay engine: display modes,
// reveal FSM states, glyph cell geometry and alphabet_rom glyph codes.
package text_pkg;

  typedef enum logic [1:0] {
    STATIC     = 2'd0,
    TYPE       = 2'd1,
    BLINK      = 2'd2,
    TYPE_BLINK = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    HOLD   = 2'd2
  } anim_state_t;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int CODE_W = 6;

  localparam logic [CODE_W-1:0] G_BLANK = 6'd0;
  localparam logic [CODE_W-1:0] G_A = 6'd1;
  localparam logic [CODE_W-1:0] G_H = 6'd8;
  localparam logic [CODE_W-1:0] G_I = 6'd9;
  localparam logic [CODE_W-1:0] G_N = 6'd14;
  localparam logic [CODE_W-1:0] G_W = 6'd23;
  localparam logic [CODE_W-1:0] G_Z = 6'd26;

  function automatic logic is_type_mode(input mode_t m);
    return (m == TYPE) || (m == TYPE_BLINK);
  endfunction

endpackage

// File: rtl/alphabet_rom.sv
// 8x16 glyph ROM, combinational read. addr = {glyph_code, row}; bit 7 of data
// is the leftmost pixel. Code 0 and codes above 26 are blank.
module alphabet_rom
  import text_pkg::*;
(
  input  logic [9:0] addr,
  output logic [7:0] data
);

  logic [127:0] glyph;
  logic [6:0]   base;

  always_comb begin
    glyph = '0;
    case (addr[9:4])
      6'd1:  glyph = 128'h00001038_6cc6c6fe_c6c6c6c6_00000000;
      6'd2:  glyph = 128'h0000fc66_66667c66_666666fc_00000000;
      6'd3:  glyph = 128'h00003c66_c2c0c0c0_c0c2663c_00000000;
      6'd4:  glyph = 128'h0000f86c_66666666_66666cf8_00000000;
      6'd5:  glyph = 128'h0000fe66_62687868_606266fe_00000000;
      6'd6:  glyph = 128'h0000fe66_62687868_606060f0_00000000;
      6'd7:  glyph = 128'h00003c66_c2c0c0de_c6c6663a_00000000;
      6'd8:  glyph = 128'h0000c6c6_c6c6fec6_c6c6c6c6_00000000;
      6'd9:  glyph = 128'h00003c18_18181818_1818183c_00000000;
      6'd10: glyph = 128'h00001e0c_0c0c0c0c_cccccc78_00000000;
      6'd11: glyph = 128'h0000e666_666c7878_6c6666e6_00000000;
      6'd12: glyph = 128'h0000f060_60606060_606266fe_00000000;
      6'd13: glyph = 128'h0000c6ee_fefed6c6_c6c6c6c6_00000000;
      6'd14: glyph = 128'h0000c6e6_f6fedece_c6c6c6c6_00000000;
      6'd15: glyph = 128'h00007cc6_c6c6c6c6_c6c6c67c_00000000;
      6'd16: glyph = 128'h0000fc66_66667c60_606060f0_00000000;
      6'd17: glyph = 128'h00007cc6_c6c6c6c6_c6d6de7c_0c0e0000;
      6'd18: glyph = 128'h0000fc66_66667c6c_666666e6_00000000;
      6'd19: glyph = 128'h00007cc6_c660380c_06c6c67c_00000000;
      6'd20: glyph = 128'h00007e7e_5a181818_1818183c_00000000;
      6'd21: glyph = 128'h0000c6c6_c6c6c6c6_c6c6c67c_00000000;
      6'd22: glyph = 128'h0000c6c6_c6c6c6c6_c66c3810_00000000;
      6'd23: glyph = 128'h0000c6c6_c6c6d6d6_d6feee6c_00000000;
      6'd24: glyph = 128'h0000c6c6_6c7c3838_7c6cc6c6_00000000;
      6'd25: glyph = 128'h00006666_66663c18_1818183c_00000000;
      6'd26: glyph = 128'h0000fec6_860c1830_60c2c6fe_00000000;
      default: glyph = '0;
    endcase
    // Row 0 sits in the top byte of the literal.
    base = {~addr[3:0], 3'b000};
    data = glyph[base +: 8];
  end

endmodule

// File: rtl/text_anim_ctrl.sv
// Animation control: latches length/mode on start, runs the typewriter reveal
// FSM and the blink counter off frame_start, and produces busy/done.
module text_anim_ctrl
  import text_pkg::*;
#(
  parameter int LEN_W         = 5,
  parameter int FRAMES_PER_CH = 4,
  parameter int BLINK_FRAMES  = 30
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_start,
  input  logic             start,
  input  logic [LEN_W-1:0] start_len,
  input  mode_t            start_mode,
  output logic [LEN_W-1:0] len,
  output mode_t            mode,
  output logic [LEN_W-1:0] reveal_cnt,
  output logic             blink_phase,
  output logic             busy,
  output logic             done
);

  localparam int FC_W = (FRAMES_PER_CH > 1) ? $clog2(FRAMES_PER_CH) : 1;
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_CH - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

  anim_state_t      state;
  logic [FC_W-1:0]  frame_cnt;
  logic [BC_W-1:0]  blink_cnt;
  logic [LEN_W-1:0] reveal_nxt;
  logic             blink_en;

  assign reveal_nxt = reveal_cnt + LEN_W'(1);
  // TYPE_BLINK holds the phase on until the reveal has finished.
  assign blink_en   = (mode == BLINK) || ((mode == TYPE_BLINK) && (state == HOLD));

  // NOTE: every flop here is assigned with <= so all of them see the same
  // pre-edge values; blocking writes would make later reads see new state.
  always_ff @(posedge Clk) begin
    done <= 1'b0;
    if (Reset) begin
      state       <= IDLE;
      len         <= '0;
      mode        <= STATIC;
      reveal_cnt  <= '0;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      busy        <= 1'b0;
    end else if (start) begin
      len         <= start_len;
      mode        <= start_mode;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      if (is_type_mode(start_mode)) begin
        reveal_cnt <= '0;
        if (start_len != '0) begin
          state <= REVEAL;
          busy  <= 1'b1;
        end else begin
          state <= HOLD;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else begin
        reveal_cnt <= start_len;
        state      <= HOLD;
        busy       <= 1'b0;
      end
    end else if (frame_start) begin
      if (state == REVEAL) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt  <= '0;
          reveal_cnt <= reveal_nxt;
          if (reveal_nxt == len) begin
            state <= HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end
      if (blink_en) begin
        if (blink_cnt == BC_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BC_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/text_overlay_engine.sv
// Scaled text sprite renderer: string buffer, box geometry and a 2-stage
// pixel pipeline (address/visibility, then ROM bit select) driving is_text.
module text_overlay_engine
  import text_pkg::*;
#(
  parameter int                MAX_CHARS     = 16,
  parameter int                SCALE         = 7,
  parameter int                GAP           = 6,
  parameter int                FRAMES_PER_CH = 4,
  parameter int                BLINK_FRAMES  = 30,
  parameter logic [CODE_W-1:0] BLANK_CODE    = '0,
  localparam int               IDX_W         = $clog2(MAX_CHARS),
  localparam int               LEN_W         = IDX_W + 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [9:0]        cfg_x,
  input  logic [9:0]        cfg_y,
  input  mode_t             cfg_mode,
  output logic              is_text,
  output logic              busy,
  output logic              done
);

  localparam int GLYPH_W = CHAR_W * SCALE;
  localparam int GLYPH_H = CHAR_H * SCALE;
  localparam int PITCH   = GLYPH_W + GAP;

  logic [CODE_W-1:0] buffer [MAX_CHARS];
  logic [9:0]        x_q, y_q;
  logic [LEN_W-1:0]  start_len, len_q, reveal_cnt;
  mode_t             mode_q;
  logic              blink_phase;

  assign start_len = (cfg_len > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : cfg_len;

  text_anim_ctrl #(
    .LEN_W        (LEN_W),
    .FRAMES_PER_CH(FRAMES_PER_CH),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_anim (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .start      (start),
    .start_len  (start_len),
    .start_mode (cfg_mode),
    .len        (len_q),
    .mode       (mode_q),
    .reveal_cnt (reveal_cnt),
    .blink_phase(blink_phase),
    .busy       (busy),
    .done       (done)
  );

  // NOTE: the buffer is a small register file, not a RAM macro, so it can and
  // does take the synchronous reset; a block RAM could not be cleared this way.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < MAX_CHARS; i++) buffer[i] <= BLANK_CODE;
      x_q <= '0;
      y_q <= '0;
    end else begin
      if (wr_en) buffer[wr_idx] <= wr_code;
      if (start) begin
        x_q <= cfg_x;
        y_q <= cfg_y;
      end
    end
  end

  logic [10:0]      dx, dy;
  logic [9:0]       dx_u, dy_u, ci, r;
  logic [15:0]      box_w;
  logic [2:0]       col;
  logic [3:0]       row;
  logic             in_box, in_glyph, revealed, vis;
  logic [IDX_W-1:0] ci_idx;

  // NOTE: every signal gets a value on every path (defaults, full case) so
  // this block stays purely combinational and infers no latches.
  always_comb begin
    dx       = {1'b0, DrawX} - {1'b0, x_q};
    dy       = {1'b0, DrawY} - {1'b0, y_q};
    dx_u     = dx[9:0];
    dy_u     = dy[9:0];
    box_w    = 16'(len_q * PITCH);
    ci       = 10'(dx_u / PITCH);
    r        = 10'(dx_u % PITCH);
    col      = 3'(r / SCALE);
    row      = 4'(dy_u / SCALE);
    in_box   = !dx[10] && !dy[10] && ({6'd0, dx_u} < box_w) && (dy_u < 10'(GLYPH_H));
    in_glyph = in_box && (r < 10'(GLYPH_W));
    revealed = ci < 10'(reveal_cnt);
    ci_idx   = in_box ? ci[IDX_W-1:0] : '0;
    vis      = 1'b0;
    case (mode_q)
      STATIC:  vis = in_glyph;
      TYPE:    vis = in_glyph && revealed;
      BLINK:   vis = in_glyph && blink_phase;
      default: vis = in_glyph && revealed && blink_phase;
    endcase
  end

  logic [9:0] addr_q;
  logic [2:0] col_q;
  logic       vis_q;
  logic [7:0] rom_data;

  alphabet_rom u_rom (
    .addr(addr_q),
    .data(rom_data)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q  <= '0;
      col_q   <= '0;
      vis_q   <= 1'b0;
      is_text <= 1'b0;
    end else begin
      addr_q  <= {buffer[ci_idx], row};
      col_q   <= col;
      vis_q   <= vis;
      is_text <= vis_q && rom_data[3'd7 - col_q];
    end
  end

endmodule

// File: tb/tb_text_overlay_engine.sv
// Directed bench for text_overlay_engine: pixel probes go through a scoreboard
// checked 2 cycles later by a monitor; control outputs are checked inline.
module tb_text_overlay_engine;
  import text_pkg::*;

  localparam int SCALE = 5;
  localparam int GAP   = 5;
  localparam int MAXC  = 16;
  localparam int PITCH = 8 * SCALE + GAP;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_idx = '0;
  logic [5:0] wr_code = '0;
  logic       start = 1'b0;
  logic [4:0] cfg_len = '0;
  logic [9:0] cfg_x = '0, cfg_y = '0;
  mode_t      cfg_mode = STATIC;
  logic       is_text, busy, done;

  text_overlay_engine #(
    .MAX_CHARS(MAXC), .SCALE(SCALE), .GAP(GAP),
    .FRAMES_PER_CH(4), .BLINK_FRAMES(30), .BLANK_CODE(6'd0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_code(wr_code),
    .start(start), .cfg_len(cfg_len), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_mode(cfg_mode),
    .is_text(is_text), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int n_run = 0, n_fail = 0, done_cnt = 0;

  typedef struct { int px; int py; bit exp; } exp_t;
  exp_t sb_q[$];
  logic       probe_en = 1'b0;
  logic [1:0] vpipe = '0;

  // Reference model state
  int    m_x = 0, m_y = 0, m_len = 0, m_reveal = 0;
  mode_t m_mode = STATIC;
  bit    m_phase = 1'b0;
  int    m_buf[MAXC];

  function automatic logic [7:0] glyph_row(input int code, input int row);
    logic [127:0] g;
    case (code)
      1:       g = 128'h00001038_6cc6c6fe_c6c6c6c6_00000000;
      8:       g = 128'h0000c6c6_c6c6fec6_c6c6c6c6_00000000;
      9:       g = 128'h00003c18_18181818_1818183c_00000000;
      14:      g = 128'h0000c6e6_f6fedece_c6c6c6c6_00000000;
      23:      g = 128'h0000c6c6_c6c6d6d6_d6feee6c_00000000;
      default: g = '0;
    endcase
    return g[(15 - row) * 8 +: 8];
  endfunction

  function automatic bit model_px(input int px, input int py);
    int dx, dy, ci, r;
    logic [7:0] bits;
    dx = px - m_x;
    dy = py - m_y;
    if (dx < 0 || dy < 0 || dx >= m_len * PITCH || dy >= 16 * SCALE) return 1'b0;
    ci = dx / PITCH;
    r  = dx % PITCH;
    if (r >= 8 * SCALE) return 1'b0;
    if ((m_mode == TYPE || m_mode == TYPE_BLINK) && ci >= m_reveal) return 1'b0;
    if ((m_mode == BLINK || m_mode == TYPE_BLINK) && !m_phase) return 1'b0;
    bits = glyph_row(m_buf[ci], dy / SCALE);
    return bits[7 - r / SCALE];
  endfunction

  always @(posedge Clk) vpipe <= {vpipe[0], probe_en};

  always @(negedge Clk) begin
    if (done) done_cnt++;
    if (vpipe[1]) begin
      n_run++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL pixel: is_text=%0b with no expected entry", is_text);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (is_text !== e.exp) begin
          n_fail++;
          $display("FAIL pixel (%0d,%0d): is_text=%0b expected %0b", e.px, e.py, is_text, e.exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic probe(input int px, input int py);
    DrawX = 10'(px);
    DrawY = 10'(py);
    probe_en = 1'b1;
    sb_q.push_back('{px, py, model_px(px, py)});
    step();
    probe_en = 1'b0;
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
    end
  endtask

  task automatic write_char(input int idx, input int code);
    wr_en = 1'b1; wr_idx = 4'(idx); wr_code = 6'(code);
    step();
    wr_en = 1'b0;
    m_buf[idx] = code;
  endtask

  task automatic do_start(input int len, input int x, input int y, input mode_t md, input bit fs);
    start = 1'b1; cfg_len = 5'(len); cfg_x = 10'(x); cfg_y = 10'(y); cfg_mode = md;
    frame_start = fs;
    step();
    start = 1'b0; frame_start = 1'b0;
    m_len = (len > MAXC) ? MAXC : len;
    m_x = x; m_y = y; m_mode = md; m_phase = 1'b1;
    m_reveal = (md == TYPE || md == TYPE_BLINK) ? 0 : m_len;
  endtask

  task automatic model_reset();
    m_len = 0; m_x = 0; m_y = 0; m_reveal = 0; m_mode = STATIC; m_phase = 1'b0;
    for (int i = 0; i < MAXC; i++) m_buf[i] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    model_reset();
    step(); step();
    Reset = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset is_text", is_text, 0);
    probe(462, 50);

    // WIN, static, full glyph sampling plus gap and box edges
    write_char(0, 23); write_char(1, 9); write_char(2, 14);
    do_start(3, 460, 40, STATIC, 1'b0);
    check("static busy", busy, 0);
    for (int c = 0; c < 3; c++)
      for (int rr = 2; rr < 14; rr += 3)
        for (int k = 0; k < 8; k++)
          probe(460 + c * PITCH + k * SCALE + 2, 40 + rr * SCALE + 3);
    for (int g = 0; g < GAP; g++) probe(460 + 40 + g, 50);
    probe(459, 50); probe(460, 39); probe(460, 120); probe(460 + 3 * PITCH, 50);

    // Typewriter reveal
    d0 = done_cnt;
    do_start(3, 460, 40, TYPE, 1'b0);
    check("type busy at start", busy, 1);
    probe(462, 50);
    frames(3); probe(462, 50);
    frames(1); m_reveal = 1; probe(462, 50); probe(517, 50);
    frames(7);
    check("busy before frame 12", busy, 1);
    check("no done before frame 12", done_cnt, d0);
    frames(1); m_reveal = 3;
    check("busy after frame 12", busy, 0);
    check("done pulse on frame 12", done_cnt, d0 + 1);
    probe(552, 50);
    frames(2);
    check("done pulsed once", done_cnt, d0 + 1);

    // Blink
    d0 = done_cnt;
    do_start(3, 460, 40, BLINK, 1'b0);
    check("blink busy", busy, 0);
    probe(462, 50);
    frames(29); probe(462, 50);
    frames(1);  m_phase = 1'b0; probe(462, 50);
    frames(29); probe(462, 50);
    frames(1);  m_phase = 1'b1; probe(462, 50);
    check("blink no done", done_cnt, d0);

    // TYPE_BLINK: blink counting starts only after reveal completes
    do_start(3, 460, 40, TYPE_BLINK, 1'b0);
    frames(12); m_reveal = 3;
    check("type_blink done", done_cnt, d0 + 1);
    frames(29); probe(552, 50);
    frames(1);  m_phase = 1'b0; probe(552, 50);

    // Restart coincident with frame_start, then reset mid-reveal
    do_start(3, 460, 40, TYPE, 1'b0);
    frames(6); m_reveal = 1; probe(462, 50);
    do_start(3, 460, 40, TYPE, 1'b1);
    check("restart busy", busy, 1);
    probe(462, 50);
    frames(3); probe(462, 50);
    frames(1); m_reveal = 1; probe(462, 50);
    drain();
    check("lit before reset", is_text, 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    model_reset();
    check("busy after reset", busy, 0);
    check("is_text after reset", is_text, 0);
    step();
    check("is_text 2 cycles after reset", is_text, 0);
    probe(462, 50);

    // Length clamp and right-edge placement
    write_char(0, 23); write_char(1, 9); write_char(2, 14); write_char(15, 8);
    do_start(20, 10, 40, STATIC, 1'b0);
    probe(10 + 15 * PITCH + 2, 50);
    probe(10 + 16 * PITCH + 2, 50);
    probe(10 + 16 * PITCH - 1, 50);
    do_start(1, 600, 40, STATIC, 1'b0);
    probe(632, 70); probe(639, 70); probe(641, 50); probe(1000, 50);

    // Live write to a displayed slot, then zero-length TYPE start
    do_start(3, 460, 40, STATIC, 1'b0);
    wr_en = 1'b1; wr_idx = 4'd1; wr_code = 6'd1;
    probe(512, 62);
    wr_en = 1'b0; m_buf[1] = 1;
    probe(512, 62);
    d0 = done_cnt;
    start = 1'b1; cfg_len = 5'd0; cfg_x = 10'd460; cfg_y = 10'd40; cfg_mode = TYPE;
    step();
    start = 1'b0;
    m_len = 0; m_mode = TYPE; m_reveal = 0; m_phase = 1'b1;
    check("len0 done pulse", done, 1);
    check("len0 busy", busy, 0);
    step();
    check("len0 done cleared", done, 0);
    probe(462, 50);
    check("len0 single done", done_cnt, d0 + 1);

    drain();
    check("scoreboard empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
